sha256_msg_padder: RTL and testbench



---
 rtl/sha256_pkg.sv | 26 ++
 rtl/sha256_msg_padder.sv | 228 ++++++++++++++++++++++
 tb/tb_sha256_msg_padder.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sha256_pkg.sv
// Shared constants, state type and last-word byte padding helper for the SHA-256 message padder.
// The helper is only referenced when SHA_PAD_BYTE_EN is defined.
package sha256_pkg;

  localparam int          SHA256_BLK_WORDS  = 16;
  localparam logic [31:0] SHA256_PAD_WORD   = 32'h8000_0000;
  localparam int          SHA256_LEN_HI_IDX = 14;
  localparam int          SHA256_LEN_LO_IDX = 15;

  typedef enum logic [1:0] {
    FILL      = 2'd0,
    BLK_OUT   = 2'd1,
    EXTRA_OUT = 2'd2
  } pad_state_t;

  // Keep the first nbytes big-endian bytes, place the 0x80 marker right after them, zero the rest.
  function automatic logic [31:0] pad_last_word(input logic [31:0] data, input logic [1:0] nbytes);
    case (nbytes)
      2'd1:    return {data[31:24], 8'h80, 16'h0000};
      2'd2:    return {data[31:16], 8'h80, 8'h00};
      2'd3:    return {data[31:8], 8'h80};
      default: return data;
    endcase
  endfunction

endpackage

// File: rtl/sha256_msg_padder.sv
// Collects 32-bit message words into 512-bit SHA-256 blocks, appending pad, zero fill and bit length.
// Optional SHA_PAD_BYTE_EN adds in_last_nbytes for messages ending in a partial word.
module sha256_msg_padder
  import sha256_pkg::*;
#(
  parameter int WCNT_W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [31:0]  in_data,
  input  logic         in_last,
`ifdef SHA_PAD_BYTE_EN
  input  logic [1:0]   in_last_nbytes,
`endif
  output logic         blk_valid,
  input  logic         blk_ready,
  output logic [511:0] blk_data,
  output logic         blk_first,
  output logic         blk_last
);

  localparam int LEN_W = WCNT_W + 5;

  pad_state_t        state_q, state_d;
  logic [31:0]       buf_q [SHA256_BLK_WORDS];
  logic [31:0]       buf_d [SHA256_BLK_WORDS];
  logic [3:0]        widx_q, widx_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic [2:0]        nb_q, nb_d;
  logic              first_pending_q, first_pending_d;
  logic              extra_pending_q, extra_pending_d;
  logic              extra_pad_q, extra_pad_d;
  logic              blk_first_q, blk_first_d;
  logic              blk_last_q, blk_last_d;

  logic [WCNT_W-1:0] wcnt_inc_s;
  logic [2:0]        last_nb_s;
  logic [31:0]       last_word_s;
  logic [4:0]        p_s;
  logic              pad_inline_s;
  logic [63:0]       len_s;
  logic [63:0]       len_x_s;

  // Bit length of a message of wcnt words whose last word carries nb (1..4) valid bytes.
  function automatic logic [63:0] bit_len(input logic [WCNT_W-1:0] wcnt, input logic [2:0] nb);
    logic [LEN_W-1:0] l;
    l = {wcnt - WCNT_W'(1), 5'd0} + LEN_W'({nb, 3'd0});
    return {{(64 - LEN_W){1'b0}}, l};
  endfunction

  // Decode the final word: where the pad marker lands and how many bytes are valid.
  always_comb begin
    wcnt_inc_s = wcnt_q + WCNT_W'(1);
`ifdef SHA_PAD_BYTE_EN
    if (in_last_nbytes != 2'd0) begin
      last_nb_s    = {1'b0, in_last_nbytes};
      last_word_s  = pad_last_word(in_data, in_last_nbytes);
      p_s          = {1'b0, widx_q};
      pad_inline_s = 1'b1;
    end else begin
      last_nb_s    = 3'd4;
      last_word_s  = in_data;
      p_s          = {1'b0, widx_q} + 5'd1;
      pad_inline_s = 1'b0;
    end
`else
    last_nb_s    = 3'd4;
    last_word_s  = in_data;
    p_s          = {1'b0, widx_q} + 5'd1;
    pad_inline_s = 1'b0;
`endif
    len_s   = bit_len(wcnt_inc_s, last_nb_s);
    len_x_s = bit_len(wcnt_q, nb_q);
  end

  // Next-state logic: word collection, block formation and handshake-driven release.
  always_comb begin
    state_d         = state_q;
    buf_d           = buf_q;
    widx_d          = widx_q;
    wcnt_d          = wcnt_q;
    nb_d            = nb_q;
    first_pending_d = first_pending_q;
    extra_pending_d = extra_pending_q;
    extra_pad_d     = extra_pad_q;
    blk_first_d     = blk_first_q;
    blk_last_d      = blk_last_q;

    case (state_q)
      FILL: begin
        if (in_valid) begin
          buf_d[widx_q] = in_last ? last_word_s : in_data;
          wcnt_d        = wcnt_inc_s;
          widx_d        = widx_q + 4'd1;
          if (in_last) begin
            nb_d        = last_nb_s;
            blk_first_d = first_pending_q;
            state_d     = BLK_OUT;
            if (!pad_inline_s && (p_s < 5'd16)) begin
              buf_d[p_s[3:0]] = SHA256_PAD_WORD;
            end else begin
              buf_d[widx_q] = last_word_s;
            end
            // The length only fits when words 14/15 are still free.
            if (p_s <= 5'd13) begin
              buf_d[SHA256_LEN_HI_IDX] = len_s[63:32];
              buf_d[SHA256_LEN_LO_IDX] = len_s[31:0];
              blk_last_d      = 1'b1;
              extra_pending_d = 1'b0;
              extra_pad_d     = 1'b0;
            end else begin
              blk_last_d      = 1'b0;
              extra_pending_d = 1'b1;
              extra_pad_d     = (p_s == 5'd16);
            end
          end else if (widx_q == 4'd15) begin
            state_d         = BLK_OUT;
            blk_first_d     = first_pending_q;
            blk_last_d      = 1'b0;
            extra_pending_d = 1'b0;
            extra_pad_d     = 1'b0;
          end else begin
            state_d = FILL;
          end
        end else begin
          state_d = FILL;
        end
      end

      BLK_OUT: begin
        if (blk_ready) begin
          for (int i = 0; i < SHA256_BLK_WORDS; i++) begin
            buf_d[i] = 32'h0000_0000;
          end
          widx_d = 4'd0;
          if (extra_pending_q) begin
            state_d                  = EXTRA_OUT;
            buf_d[0]                 = extra_pad_q ? SHA256_PAD_WORD : 32'h0000_0000;
            buf_d[SHA256_LEN_HI_IDX] = len_x_s[63:32];
            buf_d[SHA256_LEN_LO_IDX] = len_x_s[31:0];
            blk_first_d              = 1'b0;
            blk_last_d               = 1'b1;
            extra_pending_d          = 1'b0;
          end else if (blk_last_q) begin
            state_d         = FILL;
            wcnt_d          = {WCNT_W{1'b0}};
            first_pending_d = 1'b1;
            blk_first_d     = 1'b0;
            blk_last_d      = 1'b0;
          end else begin
            state_d         = FILL;
            first_pending_d = 1'b0;
            blk_first_d     = 1'b0;
            blk_last_d      = 1'b0;
          end
        end else begin
          state_d = BLK_OUT;
        end
      end

      EXTRA_OUT: begin
        if (blk_ready) begin
          for (int i = 0; i < SHA256_BLK_WORDS; i++) begin
            buf_d[i] = 32'h0000_0000;
          end
          state_d         = FILL;
          widx_d          = 4'd0;
          wcnt_d          = {WCNT_W{1'b0}};
          first_pending_d = 1'b1;
          extra_pad_d     = 1'b0;
          blk_first_d     = 1'b0;
          blk_last_d      = 1'b0;
        end else begin
          state_d = EXTRA_OUT;
        end
      end

      default: begin
        state_d = FILL;
      end
    endcase
  end

  // State, buffer and control registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= FILL;
      for (int i = 0; i < SHA256_BLK_WORDS; i++) begin
        buf_q[i] <= 32'h0000_0000;
      end
      widx_q          <= 4'd0;
      wcnt_q          <= {WCNT_W{1'b0}};
      nb_q            <= 3'd4;
      first_pending_q <= 1'b1;
      extra_pending_q <= 1'b0;
      extra_pad_q     <= 1'b0;
      blk_first_q     <= 1'b0;
      blk_last_q      <= 1'b0;
    end else begin
      state_q         <= state_d;
      buf_q           <= buf_d;
      widx_q          <= widx_d;
      wcnt_q          <= wcnt_d;
      nb_q            <= nb_d;
      first_pending_q <= first_pending_d;
      extra_pending_q <= extra_pending_d;
      extra_pad_q     <= extra_pad_d;
      blk_first_q     <= blk_first_d;
      blk_last_q      <= blk_last_d;
    end
  end

  // Flatten the buffer onto the block bus, word n at [32n+31:32n].
  always_comb begin
    blk_data = {512{1'b0}};
    for (int i = 0; i < SHA256_BLK_WORDS; i++) begin
      blk_data[32*i +: 32] = buf_q[i];
    end
  end

  assign in_ready  = (state_q == FILL);
  assign blk_valid = (state_q != FILL);
  assign blk_first = blk_first_q;
  assign blk_last  = blk_last_q;

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Self-checking bench for sha256_msg_padder: byte-level padding model, per-cycle block compare,
// plus literal expectations from hand-computed vectors.
module tb_sha256_msg_padder;

  logic         clk;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  in_data;
  logic         in_last;
`ifdef SHA_PAD_BYTE_EN
  logic [1:0]   in_last_nbytes;
`endif
  logic         blk_valid;
  logic         blk_ready;
  logic [511:0] blk_data;
  logic         blk_first;
  logic         blk_last;

  typedef struct packed {
    logic [511:0] data;
    logic         first;
    logic         last;
  } blk_t;

  blk_t        exp_q[$];
  blk_t        got_q[$];
  logic [31:0] msg_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;

  sha256_msg_padder dut (
    .clk            (clk),
    .reset          (reset),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_data        (in_data),
    .in_last        (in_last),
`ifdef SHA_PAD_BYTE_EN
    .in_last_nbytes (in_last_nbytes),
`endif
    .blk_valid      (blk_valid),
    .blk_ready      (blk_ready),
    .blk_data       (blk_data),
    .blk_first      (blk_first),
    .blk_last       (blk_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Model: message as bytes, append 0x80, zero fill to 56 mod 64, append 64-bit big-endian bit length.
  task automatic model_push(input int nb);
    logic [7:0]  bytes[$];
    logic [63:0] bitlen;
    logic [31:0] w;
    blk_t        b;
    int          nblk;
    int          base;
    for (int i = 0; i < msg_q.size(); i++) begin
      for (int k = 0; k < 4; k++) begin
        if ((i < msg_q.size() - 1) || (k < nb)) begin
          w = msg_q[i] >> (24 - 8 * k);
          bytes.push_back(w[7:0]);
        end
      end
    end
    bitlen = 64'(bytes.size()) * 64'd8;
    bytes.push_back(8'h80);
    while ((bytes.size() % 64) != 56) bytes.push_back(8'h00);
    for (int k = 7; k >= 0; k--) begin
      w = 32'(bitlen >> (8 * k));
      bytes.push_back(w[7:0]);
    end
    nblk = bytes.size() / 64;
    for (int j = 0; j < nblk; j++) begin
      b.data = {512{1'b0}};
      for (int n = 0; n < 16; n++) begin
        base = j * 64 + n * 4;
        b.data[32*n +: 32] = {bytes[base], bytes[base+1], bytes[base+2], bytes[base+3]};
      end
      b.first = (j == 0);
      b.last  = (j == nblk - 1);
      exp_q.push_back(b);
    end
  endtask

  // Compare every cycle a block is presented; record blocks that complete a handshake.
  always @(negedge clk) begin
    if (!reset) begin
      chk("in_ready_vs_blk_valid", in_ready, !blk_valid);
      if (blk_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_block", 1'b1, 1'b0);
        end else begin
          chk("blk_data", blk_data, exp_q[0].data);
          chk("blk_first", blk_first, exp_q[0].first);
          chk("blk_last", blk_last, exp_q[0].last);
          if (blk_ready) begin
            got_q.push_back('{data: blk_data, first: blk_first, last: blk_last});
            void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  task automatic send_words(input int n, input bit with_last, input int nb);
    int waited;
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = msg_q[i];
      in_last  = with_last && (i == n - 1);
`ifdef SHA_PAD_BYTE_EN
      in_last_nbytes = in_last ? 2'(nb % 4) : 2'd0;
`endif
      waited = 0;
      while (1) begin
        @(negedge clk);
        if (in_ready) break;
        waited++;
        if (waited > 200) break;
      end
      if (waited > 200) begin
        chk("in_ready_timeout", 1'b0, 1'b1);
        in_valid = 1'b0;
        in_last  = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (with_last) begin
      @(negedge clk);
      chk("blk_valid_after_last", blk_valid, 1'b1);
    end
  endtask

  task automatic drain();
    int waited;
    waited = 0;
    while (exp_q.size() != 0 && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    if (exp_q.size() != 0) chk("drain_timeout", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic run_msg(input int n, input logic [31:0] start, input int nb);
    msg_q.delete();
    got_q.delete();
    for (int i = 0; i < n; i++) msg_q.push_back(start + 32'(i));
    model_push(nb);
    send_words(n, 1'b1, nb);
    drain();
  endtask

  function automatic logic [31:0] gw(input int b, input int n);
    blk_t t;
    t = got_q[b];
    return t.data[32*n +: 32];
  endfunction

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = 32'h0;
    in_last   = 1'b0;
    blk_ready = 1'b1;
`ifdef SHA_PAD_BYTE_EN
    in_last_nbytes = 2'd0;
`endif
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_blk_valid", blk_valid, 1'b0);
    chk("rst_blk_first", blk_first, 1'b0);
    chk("rst_blk_last", blk_last, 1'b0);
    chk("rst_blk_data", blk_data, {512{1'b0}});
    @(posedge clk);
    #1;

    run_msg(20, 32'd0, 4);
    chk("m20_nblk", 32'(got_q.size()), 32'd2);
    chk("m20_a_w5", gw(0, 5), 32'd5);
    chk("m20_a_fl", {got_q[0].first, got_q[0].last}, 2'b10);
    chk("m20_b_w3", gw(1, 3), 32'd19);
    chk("m20_b_w4", gw(1, 4), 32'h8000_0000);
    chk("m20_b_w14", gw(1, 14), 32'h0);
    chk("m20_b_w15", gw(1, 15), 32'h0000_0280);
    chk("m20_b_fl", {got_q[1].first, got_q[1].last}, 2'b01);

    run_msg(14, 32'h100, 4);
    chk("m14_a_w14", gw(0, 14), 32'h8000_0000);
    chk("m14_a_w15", gw(0, 15), 32'h0);
    chk("m14_a_last", got_q[0].last, 1'b0);
    chk("m14_x_w15", gw(1, 15), 32'h0000_01C0);
    chk("m14_x_fl", {got_q[1].first, got_q[1].last}, 2'b01);

    run_msg(16, 32'h200, 4);
    chk("m16_x_w0", gw(1, 0), 32'h8000_0000);
    chk("m16_x_w14", gw(1, 14), 32'h0);
    chk("m16_x_w15", gw(1, 15), 32'h0000_0200);

    run_msg(1, 32'hDEAD_BEEF, 4);
    chk("m1_nblk", 32'(got_q.size()), 32'd1);
    chk("m1_w0", gw(0, 0), 32'hDEAD_BEEF);
    chk("m1_w1", gw(0, 1), 32'h8000_0000);
    chk("m1_w15", gw(0, 15), 32'h0000_0020);
    chk("m1_fl", {got_q[0].first, got_q[0].last}, 2'b11);

    // Backpressure: hold the first block for 10 cycles while the sender keeps offering words.
    msg_q.delete();
    got_q.delete();
    for (int i = 0; i < 20; i++) msg_q.push_back(32'h300 + 32'(i));
    model_push(4);
    blk_ready = 1'b0;
    fork
      send_words(20, 1'b1, 4);
      begin
        int w;
        w = 0;
        while (!blk_valid && w < 100) begin
          @(negedge clk);
          w++;
        end
        repeat (10) @(negedge clk);
        blk_ready = 1'b1;
      end
    join
    drain();
    chk("bp_nblk", 32'(got_q.size()), 32'd2);
    chk("bp_a_w15", gw(0, 15), 32'h30F);

    // Partial message, then reset: the partial words must be discarded.
    msg_q.delete();
    got_q.delete();
    for (int i = 0; i < 5; i++) msg_q.push_back(32'hBAD0 + 32'(i));
    send_words(5, 1'b0, 4);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("post_rst_blk_valid", blk_valid, 1'b0);
    chk("post_rst_in_ready", in_ready, 1'b1);
    @(posedge clk);
    #1;
    run_msg(1, 32'h1234_5678, 4);
    chk("post_rst_fl", {got_q[0].first, got_q[0].last}, 2'b11);
    chk("post_rst_w15", gw(0, 15), 32'h0000_0020);

`ifdef SHA_PAD_BYTE_EN
    msg_q.delete();
    got_q.delete();
    for (int i = 1; i <= 4; i++) msg_q.push_back(32'(i));
    msg_q.push_back(32'hAABB_CCDD);
    model_push(1);
    send_words(5, 1'b1, 1);
    drain();
    chk("be_w4", gw(0, 4), 32'hAA80_0000);
    chk("be_w5", gw(0, 5), 32'h0);
    chk("be_w15", gw(0, 15), 32'h0000_0088);
`endif

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
